// File: rtl/agc_chan_out_bank.sv
// rtl/agc_chan_out_bank.sv - bank of output channel registers with WRITE/WOR/WAND, read-back, GOJAM clear and min-on stretching
// Optional feature: define CHAN_FLASH_EN to gate FLASH_MASK bits of CHOUT with FLASH.
module agc_chan_out_bank #(
    parameter int          NCH        = 4,
    parameter int          WIDTH      = 14,
    parameter int          MINON      = 8,
    parameter logic [15:0] MINON_MASK = 16'h00FF,
    parameter logic [15:0] FLASH_MASK = 16'h0000,
    localparam int         AW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 CLOCK,
    input  logic                 rst_,
    input  logic                 GOJAM,
    input  logic [AW-1:0]        CHADR,
    input  logic [1:0]           MODE,
    input  logic                 WCHG_,
    input  logic                 CCHG_,
    input  logic                 RCHG_,
    input  logic [WIDTH-1:0]     CHWL_,
    input  logic                 FLASH,
    output logic [WIDTH-1:0]     CHOR_,
    output logic [NCH*WIDTH-1:0] CHOUT
);

    localparam int TW = (MINON > 0) ? $clog2(MINON + 1) : 1;
    // With stretching disabled no bit is ever treated as a jet bit.
    localparam logic [WIDTH-1:0] SMASK = (MINON > 0) ? MINON_MASK[WIDTH-1:0] : '0;
    // The timer holds the number of cycles the bit must still be driven, counting
    // the cycle that starts at the set edge, so a one-cycle pulse lasts MINON cycles.
    localparam logic [TW-1:0] TLOAD = TW'(MINON);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_WOR   = 2'b01;
    localparam logic [1:0] OP_WAND  = 2'b10;

    logic [WIDTH-1:0]     chreg   [NCH];
    logic [WIDTH-1:0]     reg_nxt [NCH];
    logic [TW-1:0]        tmr     [NCH][WIDTH];
    logic [WIDTH-1:0]     wdata;
    logic [WIDTH-1:0]     rd_data;
    logic [NCH*WIDTH-1:0] stretched;

    assign wdata = ~CHWL_;

    // Next register value: the write strobe beats the clear strobe; only the addressed channel moves.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            reg_nxt[c] = chreg[c];
            if (int'(CHADR) == c) begin
                if (!WCHG_) begin
                    case (MODE)
                        OP_WRITE: reg_nxt[c] = wdata;
                        OP_WOR:   reg_nxt[c] = chreg[c] | wdata;
                        OP_WAND:  reg_nxt[c] = chreg[c] & wdata;
                        default:  reg_nxt[c] = chreg[c];
                    endcase
                end else if (!CCHG_) begin
                    reg_nxt[c] = '0;
                end
            end
        end
    end

    // Channel registers; GOJAM wipes the whole bank.
    always_ff @(posedge CLOCK or negedge rst_) begin
        if (!rst_) begin
            for (int c = 0; c < NCH; c++) chreg[c] <= '0;
        end else if (GOJAM) begin
            for (int c = 0; c < NCH; c++) chreg[c] <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) chreg[c] <= reg_nxt[c];
        end
    end

    // Min-on timers: reload on a 0->1 transition of a jet bit, otherwise count down to zero.
    always_ff @(posedge CLOCK or negedge rst_) begin
        if (!rst_) begin
            for (int c = 0; c < NCH; c++)
                for (int b = 0; b < WIDTH; b++) tmr[c][b] <= '0;
        end else if (GOJAM) begin
            for (int c = 0; c < NCH; c++)
                for (int b = 0; b < WIDTH; b++) tmr[c][b] <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                for (int b = 0; b < WIDTH; b++) begin
                    if (SMASK[b] && reg_nxt[c][b] && !chreg[c][b])
                        tmr[c][b] <= TLOAD;
                    else if (tmr[c][b] != '0)
                        tmr[c][b] <= tmr[c][b] - TW'(1);
                end
            end
        end
    end

    // Read mux; an out-of-range address reads as an idle (all ones) bus.
    always_comb begin
        rd_data = '1;
        for (int c = 0; c < NCH; c++)
            if (int'(CHADR) == c) rd_data = ~chreg[c];
    end

    // Registered read bus: shows the pre-edge register while RCHG_ is low, idle otherwise.
    always_ff @(posedge CLOCK or negedge rst_) begin
        if (!rst_)
            CHOR_ <= '1;
        else if (GOJAM || RCHG_)
            CHOR_ <= '1;
        else
            CHOR_ <= rd_data;
    end

    // Output drive: register bit held on for as long as its timer is still running.
    always_comb begin
        stretched = '0;
        for (int c = 0; c < NCH; c++)
            for (int b = 0; b < WIDTH; b++)
                stretched[c*WIDTH + b] = chreg[c][b] | (tmr[c][b] != '0);
    end

`ifdef CHAN_FLASH_EN
    // Display bits in FLASH_MASK blink with FLASH; storage and read-back stay unflashed.
    always_comb begin
        CHOUT = stretched;
        for (int c = 0; c < NCH; c++)
            for (int b = 0; b < WIDTH; b++)
                if (FLASH_MASK[b]) CHOUT[c*WIDTH + b] = stretched[c*WIDTH + b] & FLASH;
    end
`else
    logic unused_flash;
    assign unused_flash = FLASH ^ (|FLASH_MASK);

    // No flash gating in this build: outputs are the stretched register bits.
    always_comb begin
        CHOUT = stretched;
    end
`endif

endmodule

// File: tb/tb_agc_chan_out_bank.sv
// tb/tb_agc_chan_out_bank.sv - directed self-checking bench for agc_chan_out_bank
module tb_agc_chan_out_bank;

    localparam int NCH   = 3;
    localparam int WIDTH = 14;
    localparam int AW    = 2;

    logic                 CLOCK = 1'b0;
    logic                 rst_;
    logic                 GOJAM;
    logic [AW-1:0]        CHADR;
    logic [1:0]           MODE;
    logic                 WCHG_;
    logic                 CCHG_;
    logic                 RCHG_;
    logic [WIDTH-1:0]     CHWL_;
    logic                 FLASH;
    logic [WIDTH-1:0]     CHOR_;
    logic [NCH*WIDTH-1:0] CHOUT;

    int n_chk  = 0;
    int n_pass = 0;
    int cnt;
    logic exp_b13;

    agc_chan_out_bank #(
        .NCH        (NCH),
        .WIDTH      (WIDTH),
        .MINON      (8),
        .MINON_MASK (16'h00FF),
        .FLASH_MASK (16'h2000)
    ) dut (
        .CLOCK (CLOCK),
        .rst_  (rst_),
        .GOJAM (GOJAM),
        .CHADR (CHADR),
        .MODE  (MODE),
        .WCHG_ (WCHG_),
        .CCHG_ (CCHG_),
        .RCHG_ (RCHG_),
        .CHWL_ (CHWL_),
        .FLASH (FLASH),
        .CHOR_ (CHOR_),
        .CHOUT (CHOUT)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input int ch, input logic [1:0] mode, input logic [WIDTH-1:0] d);
        CHADR = AW'(ch);
        MODE  = mode;
        CHWL_ = ~d;
        WCHG_ = 1'b0;
        step();
        WCHG_ = 1'b1;
        CHWL_ = '1;
    endtask

    function automatic logic [WIDTH-1:0] chan(input int c);
        return CHOUT[c*WIDTH +: WIDTH];
    endfunction

    initial begin
        rst_ = 1'b0; GOJAM = 1'b0; CHADR = '0; MODE = 2'b00;
        WCHG_ = 1'b1; CCHG_ = 1'b1; RCHG_ = 1'b1; CHWL_ = '1; FLASH = 1'b0;

        // reset state
        idle(2);
        check("rst_chout", CHOUT, 0);
        check("rst_chor", CHOR_, 14'h3FFF);
        #2 rst_ = 1'b1;
        idle(2);
        check("post_rst_chout", CHOUT, 0);

        // WRITE / WOR / WAND on channel 2
        wr(2, 2'b00, 14'h0F0F);
        check("ch2_write", chan(2), 14'h0F0F);
        wr(2, 2'b01, 14'h3000);
        check("ch2_wor", chan(2), 14'h3F0F);
        idle(10);
        wr(2, 2'b10, 14'h3F00);
        check("ch2_wand", chan(2), 14'h3F00);
        wr(2, 2'b11, 14'h0000);
        check("ch2_noop", chan(2), 14'h3F00);
        CHADR = 2'd2; RCHG_ = 1'b0;
        step();
        check("ch2_read", CHOR_, 14'h00FF);
        RCHG_ = 1'b1;
        step();
        check("read_idle", CHOR_, 14'h3FFF);

        // min-on on masked bit 0: one-cycle pulse stays high 8 cycles
        cnt = 0;
        wr(0, 2'b00, 14'h0001); if (CHOUT[0]) cnt++;
        wr(0, 2'b00, 14'h0000); if (CHOUT[0]) cnt++;
        for (int i = 0; i < 12; i++) begin step(); if (CHOUT[0]) cnt++; end
        check("minon_b0", cnt, 8);

        // unmasked bit 8: one cycle only
        cnt = 0;
        wr(0, 2'b00, 14'h0100); if (CHOUT[8]) cnt++;
        wr(0, 2'b00, 14'h0000); if (CHOUT[8]) cnt++;
        for (int i = 0; i < 12; i++) begin step(); if (CHOUT[8]) cnt++; end
        check("unmasked_b8", cnt, 1);

        // re-set while stretching reloads the full on-time
        wr(0, 2'b00, 14'h0002);
        wr(0, 2'b00, 14'h0000);
        idle(3);
        cnt = 0;
        wr(0, 2'b00, 14'h0002); if (CHOUT[1]) cnt++;
        wr(0, 2'b00, 14'h0000); if (CHOUT[1]) cnt++;
        for (int i = 0; i < 12; i++) begin step(); if (CHOUT[1]) cnt++; end
        check("minon_reload", cnt, 8);

        // write beats clear; clear alone zeroes the register
        CCHG_ = 1'b0;
        wr(1, 2'b00, 14'h0505);
        check("wr_over_clr", chan(1), 14'h0505);
        CHADR = 2'd1;
        step();
        CCHG_ = 1'b1;
        check("clr_stretch", chan(1), 14'h0005);
        idle(10);
        check("clr_done", chan(1), 14'h0000);

        // out-of-range channel
        wr(3, 2'b00, 14'h3FFF);
        check("oor_write", CHOUT, {14'h3F00, 14'h0000, 14'h0000});
        CHADR = 2'd3; RCHG_ = 1'b0;
        step();
        check("oor_read", CHOR_, 14'h3FFF);
        RCHG_ = 1'b1;

        // GOJAM truncates stretching
        wr(0, 2'b00, 14'h0010);
        wr(0, 2'b00, 14'h0000);
        idle(2);
        check("pre_gojam_b4", CHOUT[4], 1'b1);
        GOJAM = 1'b1;
        step();
        GOJAM = 1'b0;
        check("gojam_clear", CHOUT, 0);
        step();
        check("gojam_timers", CHOUT, 0);
        wr(2, 2'b00, 14'h0100);
        check("post_gojam_wr", chan(2), 14'h0100);

        // flash gating of bit 13 on channel 1
        wr(1, 2'b00, 14'h2000);
        CHADR = 2'd1; RCHG_ = 1'b0;
        for (int i = 0; i < 4; i++) begin
            FLASH = (i % 2 == 1);
            step();
`ifdef CHAN_FLASH_EN
            exp_b13 = FLASH;
`else
            exp_b13 = 1'b1;
`endif
            check("flash_b13", CHOUT[WIDTH + 13], exp_b13);
            check("flash_readback", CHOR_[13], 1'b0);
        end
        RCHG_ = 1'b1; FLASH = 1'b0;

        // asynchronous reset mid-stretch with the read bus active
        wr(0, 2'b00, 14'h0001);
        wr(0, 2'b00, 14'h0000);
        CHADR = 2'd2; RCHG_ = 1'b0;
        step();
        check("pre_rst_read", CHOR_, 14'h3EFF);
        #2 rst_ = 1'b0;
        #1;
        check("async_rst_chout", CHOUT, 0);
        check("async_rst_chor", CHOR_, 14'h3FFF);
        #2 rst_ = 1'b1;
        RCHG_ = 1'b1;
        idle(2);
        check("post_async_rst", CHOUT, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
